bus2_line_master: RTL and testbench

Cache-side bus2 initiator that moves one cache line between the cache datapath and the memory controller. It takes a single-cycle line request from the cache, runs the bus2 command / data / response protocol on the shared tri-state A2/D2/C2 wires, and returns read data or completion to the cache. It sits directly upstream of the memory controller and is the only bus2 master.

---
 rtl/bus2_line_master_if.sv | 22 ++
 rtl/bus2_line_master.sv | 142 ++++++++++++++
 tb/tb_bus2_line_master.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/bus2_line_master_if.sv
// bus2_line_master_if: cache-side line request/response handshake for bus2_line_master
interface bus2_line_master_if #(
    parameter int ADDR_W = 10,
    parameter int LINE_W = 128
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LINE_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [LINE_W-1:0] rsp_rdata;
    logic              rsp_err;
    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/bus2_line_master.sv
// bus2_line_master: moves one cache line over the tri-state bus2 A2/D2/C2 wires.
// Define BUS2_TIMEOUT_EN to abort WAIT_RSP after TIMEOUT_CYCLES with rsp_err.
module bus2_line_master #(
    parameter int CACHE_ADDR_SIZE = 10,
    parameter int DATA2_BUS_SIZE  = 16,
    parameter int CTR2_BUS_SIZE   = 2,
    parameter int LINE_BYTES      = 16,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                       CLK,
    input  logic                       RESET,
    inout  wire [CACHE_ADDR_SIZE-1:0]  A2_WIRE,
    inout  wire [DATA2_BUS_SIZE-1:0]   D2_WIRE,
    inout  wire [CTR2_BUS_SIZE-1:0]    C2_WIRE,
    bus2_line_master_if.slave          cache
);
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int BEATS  = LINE_W / DATA2_BUS_SIZE;
    localparam int CW     = $clog2(BEATS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam logic [CTR2_BUS_SIZE-1:0] C2_NOP        = CTR2_BUS_SIZE'(0);
    localparam logic [CTR2_BUS_SIZE-1:0] C2_RESPONSE   = CTR2_BUS_SIZE'(1);
    localparam logic [CTR2_BUS_SIZE-1:0] C2_READ_LINE  = CTR2_BUS_SIZE'(2);
    localparam logic [CTR2_BUS_SIZE-1:0] C2_WRITE_LINE = CTR2_BUS_SIZE'(3);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_WDATA = 3'd2;
    localparam logic [2:0] S_TURN  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_RDATA = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]                 state;
    logic                       is_wr;
    logic [CACHE_ADDR_SIZE-1:0] addr;
    logic [LINE_W-1:0]          line;
    logic [LINE_W-1:0]          rdata;
    logic [CW-1:0]              beat;
    logic [CW-1:0]              nxt;
    logic                       bus_oe;
    logic                       d2_oe;
    logic [DATA2_BUS_SIZE-1:0]  d2_q;
    logic [CTR2_BUS_SIZE-1:0]   c2_q;
    logic                       ready;
    logic                       valid;
    logic                       err;
    logic                       rsp_hit;
    logic                       expired;

    assign nxt     = beat + 1'b1;
    assign rsp_hit = C2_WIRE == C2_RESPONSE;

`ifdef BUS2_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;
    assign expired = wait_cnt == TW'(TIMEOUT_CYCLES);
    always_ff @(posedge CLK) begin
        wait_cnt <= (!RESET && state == S_WAIT) ? wait_cnt + 1'b1 : '0;
    end
`else
    logic unused_cfg;
    assign expired    = 1'b0;
    assign unused_cfg = TIMEOUT_CYCLES > 0;
`endif

    // line doubles as write buffer and read capture buffer
    always_ff @(posedge CLK) begin
        valid <= 1'b0;
        err   <= 1'b0;
        if (RESET) begin
            state  <= S_IDLE;
            ready  <= 1'b1;
            bus_oe <= 1'b0;
            d2_oe  <= 1'b0;
            rdata  <= '0;
        end else begin
            case (state)
                S_IDLE: if (cache.req_valid) begin
                    state  <= S_CMD;
                    ready  <= 1'b0;
                    is_wr  <= cache.req_write;
                    addr   <= cache.req_addr;
                    line   <= cache.req_wdata;
                    bus_oe <= 1'b1;
                    d2_oe  <= cache.req_write;
                    d2_q   <= cache.req_wdata[DATA2_BUS_SIZE-1:0];
                    c2_q   <= cache.req_write ? C2_WRITE_LINE : C2_READ_LINE;
                    beat   <= CW'(1);
                end
                S_CMD: begin
                    state  <= is_wr ? S_WDATA : S_TURN;
                    bus_oe <= is_wr;
                    d2_oe  <= is_wr;
                    c2_q   <= C2_NOP;
                    d2_q   <= line[DATA2_BUS_SIZE +: DATA2_BUS_SIZE];
                end
                S_WDATA: begin
                    beat <= nxt;
                    d2_q <= line[int'(nxt) * DATA2_BUS_SIZE +: DATA2_BUS_SIZE];
                    if (beat == LAST_BEAT) begin
                        state  <= S_TURN;
                        bus_oe <= 1'b0;
                        d2_oe  <= 1'b0;
                    end
                end
                S_TURN: state <= S_WAIT;
                S_WAIT: if (rsp_hit) begin
                    state <= is_wr ? S_DONE : S_RDATA;
                    valid <= is_wr;
                    beat  <= CW'(1);
                    line[DATA2_BUS_SIZE-1:0] <= D2_WIRE;
                end else if (expired) begin
                    state <= S_DONE;
                    valid <= 1'b1;
                    err   <= 1'b1;
                end
                S_RDATA: begin
                    beat <= nxt;
                    line[int'(beat) * DATA2_BUS_SIZE +: DATA2_BUS_SIZE] <= D2_WIRE;
                    if (beat == LAST_BEAT) begin
                        state <= S_DONE;
                        valid <= 1'b1;
                        rdata <= {D2_WIRE, line[LINE_W-DATA2_BUS_SIZE-1:0]};
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign A2_WIRE = bus_oe ? addr : {CACHE_ADDR_SIZE{1'bz}};
    assign C2_WIRE = bus_oe ? c2_q : {CTR2_BUS_SIZE{1'bz}};
    assign D2_WIRE = d2_oe ? d2_q : {DATA2_BUS_SIZE{1'bz}};
    assign cache.req_ready = ready;
    assign cache.rsp_valid = valid;
    assign cache.rsp_rdata = rdata;
    assign cache.rsp_err   = err;
endmodule

// File: tb/tb_bus2_line_master.sv
// tb_bus2_line_master: random and directed line transfers against a cycle-timeline model with a memory controller stub.
module tb_bus2_line_master;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  wire [9:0]  a2_wire;
  wire [15:0] d2_wire;
  wire [1:0]  c2_wire;
  logic        mc_c2_en = 1'b0;
  logic        mc_d2_en = 1'b0;
  logic [1:0]  mc_c2 = 2'd0;
  logic [15:0] mc_d2 = 16'd0;
  assign c2_wire = mc_c2_en ? mc_c2 : 2'bz;
  assign d2_wire = mc_d2_en ? mc_d2 : 16'bz;
  bus2_line_master_if #(.ADDR_W(10), .LINE_W(128)) cif();
  bus2_line_master #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(clk), .RESET(rst), .A2_WIRE(a2_wire), .D2_WIRE(d2_wire), .C2_WIRE(c2_wire), .cache(cif)
  );
  int n_chk = 0;
  int n_fail = 0;
  logic [127:0] mem [logic [9:0]];
  logic [127:0] last_rd = '0;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] bt(input logic [127:0] l, input int i);
    return l[16*i +: 16];
  endfunction
  function automatic logic [127:0] rnd_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  task automatic check_released(input string tag);
    chk({tag, "_a2z"}, a2_wire, 10'bz);
    chk({tag, "_c2z"}, c2_wire, 2'bz);
    chk({tag, "_d2z"}, d2_wire, 16'bz);
  endtask
  task automatic xfer(input logic w, input logic [9:0] a, input logic [127:0] wd, input int d, input int stop);
    logic [127:0] ln;
    logic exp_err;
    int ws, rn, dn, lim, k;
    ws = w ? 10 : 3;
    if (!w && !mem.exists(a)) mem[a] = rnd_line();
    ln = w ? wd : mem[a];
    rn = d < 0 ? -1 : ws + d;
    dn = d < 0 ? -1 : ws + d + (w ? 1 : 8);
    exp_err = 1'b0;
`ifdef BUS2_TIMEOUT_EN
    if (d < 0) begin
      dn = ws + TO + 1;
      exp_err = 1'b1;
    end
`endif
    lim = stop > 0 ? stop : dn;
    @(negedge clk);
    #1;
    chk("ready_idle", cif.req_ready, 1'b1);
    chk("valid_idle", cif.rsp_valid, 1'b0);
    cif.req_valid = 1'b1;
    cif.req_write = w;
    cif.req_addr  = a;
    cif.req_wdata = w ? wd : rnd_line();
    for (int n = 1; n <= lim; n++) begin
      @(negedge clk);
      mc_c2_en = 1'b0;
      mc_d2_en = 1'b0;
      cif.req_valid = 1'b0;
      #1;
      chk("ready_busy", cif.req_ready, 1'b0);
      chk("rsp_valid", cif.rsp_valid, (n == dn));
      if (n == 1) begin
        chk("cmd_c2", c2_wire, (w ? 2'd3 : 2'd2));
        chk("cmd_a2", a2_wire, a);
        if (w) chk("cmd_d2", d2_wire, bt(ln, 0));
        else   chk("cmd_d2z", d2_wire, 16'bz);
      end else if (w && n <= 8) begin
        chk("wd_c2", c2_wire, 2'd0);
        chk("wd_a2", a2_wire, a);
        chk("wd_d2", d2_wire, bt(ln, n - 1));
      end else begin
        check_released("rel");
      end
      if (n == dn) begin
        if (!w && !exp_err) last_rd = ln;
        chk("rsp_err", cif.rsp_err, exp_err);
        chk("rsp_rdata", cif.rsp_rdata, last_rd);
      end
      if (n == rn) begin
        mc_c2 = 2'd1;
        mc_c2_en = 1'b1;
        if (!w) begin
          mc_d2 = bt(ln, 0);
          mc_d2_en = 1'b1;
        end
      end else if (n >= ws && (rn < 0 || n < rn) && n != dn && $urandom_range(1) == 1) begin
        k = $urandom_range(2);
        mc_c2 = k == 0 ? 2'd0 : 2'(k + 1);
        mc_c2_en = 1'b1;
      end
      if (!w && rn > 0 && n > rn && n <= rn + 7) begin
        mc_d2 = bt(ln, n - rn);
        mc_d2_en = 1'b1;
      end
    end
    if (w && d >= 0 && stop == 0) mem[a] = wd;
  endtask
  task automatic do_reset();
    @(negedge clk);
    mc_c2_en = 1'b0;
    mc_d2_en = 1'b0;
    cif.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    last_rd = '0;
    chk("rst_ready", cif.req_ready, 1'b1);
    chk("rst_valid", cif.rsp_valid, 1'b0);
    chk("rst_err", cif.rsp_err, 1'b0);
    chk("rst_rdata", cif.rsp_rdata, last_rd);
    check_released("rst");
    rst = 1'b0;
  endtask
  task automatic idle_pulse();
    @(negedge clk);
    mc_c2 = 2'd1;
    mc_d2 = 16'($urandom());
    mc_c2_en = 1'b1;
    mc_d2_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      mc_c2_en = 1'b0;
      mc_d2_en = 1'b0;
      #1;
      chk("ip_ready", cif.req_ready, 1'b1);
      chk("ip_valid", cif.rsp_valid, 1'b0);
      check_released("ip");
    end
  endtask
  initial begin
    logic [127:0] l;
    logic [9:0] a;
    int p;
    cif.req_valid = 1'b0;
    cif.req_write = 1'b0;
    cif.req_addr  = '0;
    cif.req_wdata = '0;
    do_reset();
    idle_pulse();
    for (int i = 0; i < 8; i++) l[16*i +: 16] = 16'(16'h1111 * (i + 1));
    xfer(1'b1, 10'h05A, l, 2, 0);
    for (int i = 0; i < 8; i++) l[16*i +: 16] = 16'(16'hA000 + i);
    mem[10'h3FF] = l;
    xfer(1'b0, 10'h3FF, '0, 0, 0);
    chk("rd_lo", cif.rsp_rdata[15:0], 16'hA000);
    chk("rd_hi", cif.rsp_rdata[127:112], 16'hA007);
    xfer(1'b1, 10'h123, rnd_line(), 1, 0);
    xfer(1'b0, 10'h123, '0, 0, 0);
    for (int i = 0; i < 24; i++) begin
      p = $urandom_range(3);
      a = p == 0 ? 10'h05A : p == 1 ? 10'h3FF : p == 2 ? 10'h123 : 10'($urandom_range(1023));
      xfer(1'($urandom_range(1)), a, rnd_line(), $urandom_range(4), 0);
    end
    xfer(1'b0, 10'h2AA, '0, -1, 6);
    do_reset();
    idle_pulse();
    xfer(1'b0, 10'h05A, '0, 1, 0);
`ifdef BUS2_TIMEOUT_EN
    xfer(1'b1, 10'h0F0, rnd_line(), -1, 0);
    xfer(1'b0, 10'h0F0, '0, -1, 0);
`else
    xfer(1'b0, 10'h0F0, '0, -1, 3 + 1000);
    do_reset();
`endif
    xfer(1'b1, 10'h0F0, rnd_line(), 0, 0);
    xfer(1'b0, 10'h0F0, '0, 3, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
